// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Moore control sequencer for the multicycle datapath. Decodes the opcode
//   field IR[31:26] and walks FETCH -> DECODE -> execute/memory/writeback
//   states, driving the packed 16-bit control bundle for each state.
//   It also provides stall gating, halt detection, an illegal-opcode pulse
//   and a retired-instruction counter.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   input_signal   [5:0] opcode, IR[31:26]
//   stall          hold state, suppress control, pulses and counting
//   output_signal  [15:0] control bundle (combinational from state/stall/reset)
//   state_out      [3:0] current state register
//   halted         high while in HALT (low while reset is asserted)
//   illegal_op     registered one-cycle pulse after DECODE sees a bad opcode
//   instr_done     high in the terminal cycle of each instruction
//   retired_count  [CNT_WIDTH-1:0] retired instruction count, wraps
module multicycle_control_fsm #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           input_signal,
  input  logic                 stall,
  output logic [15:0]          output_signal,
  output logic [3:0]           state_out,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CTRL_W  = 16;

  // State encodings are fixed: state_out exposes them directly.
  localparam logic [STATE_W-1:0] S_FETCH    = 4'h0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'h1;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'h2;
  localparam logic [STATE_W-1:0] S_EXEC_I   = 4'h3;
  localparam logic [STATE_W-1:0] S_WB_R     = 4'h4;
  localparam logic [STATE_W-1:0] S_WB_I     = 4'h5;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'h6;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'h7;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'h8;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'h9;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'hA;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'hB;
  localparam logic [STATE_W-1:0] S_HALT     = 4'hF;

  // Exact-match opcodes (R/I types are matched on the top two bits only).
  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b110001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Field encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNC  = 2'b10;
  localparam logic [1:0] ALUOP_IFUNC  = 2'b11;
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_ONE     = 2'b01;
  localparam logic [1:0] SRCB_SIMM    = 2'b10;

  // Control bundle layout, MSB first.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  ctrl_t              ctrl;
  logic               terminal;

  // Opcode classification
  logic op_rtype;
  logic op_itype;
  logic op_lw;
  logic op_sw;
  logic op_beq;
  logic op_j;
  logic op_halt;
  logic op_illegal;

  always_comb begin
    op_rtype   = (input_signal[5:4] == 2'b00);
    op_itype   = (input_signal[5:4] == 2'b01);
    op_lw      = (input_signal == OP_LW);
    op_sw      = (input_signal == OP_SW);
    op_beq     = (input_signal == OP_BEQ);
    op_j       = (input_signal == OP_J);
    op_halt    = (input_signal == OP_HALT);
    op_illegal = !(op_rtype || op_itype || op_lw || op_sw ||
                   op_beq || op_j || op_halt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state, per-state control bundle and terminal-state flag
  always_comb begin
    state_next = state;
    ctrl       = '0;
    terminal   = 1'b0;

    case (state)
      S_FETCH: begin
        ctrl.pc_write  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRCB_ONE;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRCB_SIMM;
        if (op_rtype)             state_next = S_EXEC_R;
        else if (op_itype)        state_next = S_EXEC_I;
        else if (op_lw || op_sw)  state_next = S_MEM_ADDR;
        else if (op_beq)          state_next = S_BRANCH;
        else if (op_j)            state_next = S_JUMP;
        else if (op_halt)         state_next = S_HALT;
        else                      state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ctrl.alu_op    = ALUOP_RFUNC;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_src_a = 1'b1;
        state_next     = S_WB_R;
      end
      S_EXEC_I: begin
        ctrl.alu_op    = ALUOP_IFUNC;
        ctrl.alu_src_b = SRCB_SIMM;
        ctrl.alu_src_a = 1'b1;
        state_next     = S_WB_I;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        terminal       = 1'b1;
        state_next     = S_FETCH;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        terminal       = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRCB_SIMM;
        ctrl.alu_src_a = 1'b1;
        // Opcode re-sampled here; anything but LW/SW aborts to FETCH.
        if (op_lw)      state_next = S_MEM_RD;
        else if (op_sw) state_next = S_MEM_WR;
        else            state_next = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        state_next    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        terminal        = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        terminal       = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_src_a     = 1'b1;
        terminal           = 1'b1;
        state_next         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        terminal       = 1'b1;
        state_next     = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        // Unused encodings recover to FETCH with all control low.
        state_next = S_FETCH;
      end
    endcase

    // Stall freezes the state regardless of what the decode above chose.
    if (stall) begin
      state_next = state;
    end
  end

  // Status outputs are Moore functions of state, gated by stall/reset.
  always_comb begin
    output_signal = (reset || stall) ? '0 : CTRL_W'(ctrl);
    instr_done    = terminal && !stall && !reset;
    halted        = (state == S_HALT) && !reset;
    state_out     = state;
  end

  // Illegal-opcode pulse, registered one cycle after DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= (state == S_DECODE) && !stall && op_illegal;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (instr_done) begin
      retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Inputs change 2 time units
// after each rising edge; outputs are checked 1 unit later, well before the
// next rising edge.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  input_signal;
  logic        stall;
  logic [15:0] output_signal;
  logic [3:0]  state_out;
  logic        halted;
  logic        illegal_op;
  logic        instr_done;
  logic [15:0] retired_count;

  int n_assert;
  int n_fail;

  multicycle_control_fsm #(.CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_signal  (input_signal),
    .stall         (stall),
    .output_signal (output_signal),
    .state_out     (state_out),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .instr_done    (instr_done),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Check every status output for the current cycle.
  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [15:0] out,
                            input logic done, input logic ill, input logic hlt,
                            input logic [15:0] cnt);
    #1;
    check($sformatf("%s.state", tag), 32'(state_out), 32'(st));
    check($sformatf("%s.out", tag), 32'(output_signal), 32'(out));
    check($sformatf("%s.done", tag), 32'(instr_done), 32'(done));
    check($sformatf("%s.ill", tag), 32'(illegal_op), 32'(ill));
    check($sformatf("%s.halted", tag), 32'(halted), 32'(hlt));
    check($sformatf("%s.count", tag), 32'(retired_count), 32'(cnt));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    stall        = 1'b0;
    input_signal = 6'b000010;

    // Reset held: FETCH, control and status low.
    cyc(); cyc();
    expect_cyc("rst_hold", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);

    // R-type 000010: 0,1,2,4 then FETCH with one retired.
    reset = 1'b0;
    expect_cyc("r_fetch", 4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("r_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("r_exec",   4'h2, 16'h0044, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("r_wb",     4'h4, 16'h0003, 1'b1, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("r_done",   4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd1);

    // LW 100000: 0,1,6,7,8.
    input_signal = 6'b100000;
    cyc(); expect_cyc("lw_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(); expect_cyc("lw_addr",   4'h6, 16'h0014, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(); expect_cyc("lw_memrd",  4'h7, 16'h3000, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(); expect_cyc("lw_memwb",  4'h8, 16'h0402, 1'b1, 1'b0, 1'b0, 16'd1);
    cyc(); expect_cyc("lw_done",   4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd2);

    // SW 100001: 0,1,6,9.
    input_signal = 6'b100001;
    cyc(); expect_cyc("sw_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd2);
    cyc(); expect_cyc("sw_addr",   4'h6, 16'h0014, 1'b0, 1'b0, 1'b0, 16'd2);
    cyc(); expect_cyc("sw_memwr",  4'h9, 16'h2800, 1'b1, 1'b0, 1'b0, 16'd2);
    cyc(); expect_cyc("sw_done",   4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd3);

    // BEQ 110000 and J 110001: three cycles each.
    input_signal = 6'b110000;
    cyc(); expect_cyc("beq_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc(); expect_cyc("beq_branch", 4'hA, 16'h80A4, 1'b1, 1'b0, 1'b0, 16'd3);
    cyc(); expect_cyc("beq_done",   4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd4);
    input_signal = 6'b110001;
    cyc(); expect_cyc("j_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc(); expect_cyc("j_jump",   4'hB, 16'h4100, 1'b1, 1'b0, 1'b0, 16'd4);
    cyc(); expect_cyc("j_done",   4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd5);

    // Illegal 101111: DECODE back to FETCH, pulse unaffected by stall.
    input_signal = 6'b101111;
    cyc(); expect_cyc("ill_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc();
    stall        = 1'b1;
    input_signal = 6'b010011;
    expect_cyc("ill_pulse", 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd5);
    cyc(); expect_cyc("ill_after", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    stall = 1'b0;
    expect_cyc("ill_resume", 4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd5);

    // I-type 010011 with a 3-cycle stall in EXEC_I.
    cyc(); expect_cyc("i_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc(); expect_cyc("i_exec",   4'h3, 16'h0074, 1'b0, 1'b0, 1'b0, 16'd5);
    stall = 1'b1;
    expect_cyc("i_stall0", 4'h3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc(); expect_cyc("i_stall1", 4'h3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc(); expect_cyc("i_stall2", 4'h3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    stall = 1'b0;
    expect_cyc("i_release", 4'h3, 16'h0074, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc();
    // Stall in the terminal cycle hides instr_done and blocks the count.
    stall = 1'b1;
    expect_cyc("i_wb_stall", 4'h5, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc(); expect_cyc("i_wb_hold", 4'h5, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5);
    stall = 1'b0;
    expect_cyc("i_wb", 4'h5, 16'h0002, 1'b1, 1'b0, 1'b0, 16'd5);
    cyc(); expect_cyc("i_done", 4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd6);

    // HALT 111111: absorbing, no count.
    input_signal = 6'b111111;
    cyc(); expect_cyc("h_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd6);
    for (int i = 0; i < 22; i++) begin
      cyc();
      expect_cyc($sformatf("h_halt%0d", i), 4'hF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd6);
    end

    // Reset out of HALT: halted drops while reset is held.
    reset = 1'b1;
    expect_cyc("h_rst_same", 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd6);
    cyc(); expect_cyc("h_rst_edge", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    input_signal = 6'b100000;
    expect_cyc("p2_fetch", 4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd0);

    // LW aborted by reset in MEM_RD.
    cyc(); expect_cyc("p2_decode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("p2_addr",   4'h6, 16'h0014, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("p2_memrd",  4'h7, 16'h3000, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    expect_cyc("p2_rst_same", 4'h7, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("p2_rst1", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("p2_rst2", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    expect_cyc("p2_refetch", 4'h0, 16'h4208, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(); expect_cyc("p2_redecode", 4'h1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
